// File: rtl/rom_msg_sender_pkg.sv
// Shared types and constants for the ROM message player.
// DEF_TERM must match the terminator used by the payload-generation script.
package rom_msg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DATA  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] DEF_TERM = 8'h00;

  function automatic int addr_w(input int sel_w, input int slot_w);
    return sel_w + slot_w;
  endfunction

endpackage

// File: rtl/rom_msg_sender_if.sv
// Bus bundle between the message player, the ROM read port and the UART tx side.
// master = player, slave = environment (ROM, UART, start source).
interface rom_msg_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2,
  parameter int SLOT_W = 6
);
  localparam int ADDR_W = rom_msg_pkg::addr_w(SEL_W, SLOT_W);

  logic              start;
  logic [SEL_W-1:0]  msg_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              tx_full;
  logic              wr;
  logic [DATA_W-1:0] w_data;
  logic              busy;
  logic              done_tick;

  modport master (
    input  start, msg_sel, rd_data, tx_full,
    output rd_addr, wr, w_data, busy, done_tick
  );

  modport slave (
    output start, msg_sel, rd_data, tx_full,
    input  rd_addr, wr, w_data, busy, done_tick
  );
endinterface

// File: rtl/rom_msg_sender.sv
// Streams a terminator-delimited message from a 1-cycle-latency ROM slot into the UART tx FIFO.
// Define ROM_MSG_SENDER_REPEAT_EN to add repeat_mode (loop the selected message until cleared).
module rom_msg_sender
  import rom_msg_pkg::*;
#(
  parameter int              DATA_W = 8,
  parameter int              SEL_W  = 2,
  parameter int              SLOT_W = 6,
  parameter logic [DATA_W-1:0] TERM = DATA_W'(DEF_TERM)
) (
  input logic clk,
  input logic reset_n,
`ifdef ROM_MSG_SENDER_REPEAT_EN
  input logic repeat_mode,
`endif
  rom_msg_if.master bus
);

  state_t              state_r, state_s;
  logic [SEL_W-1:0]    sel_r, sel_s;
  logic [SLOT_W-1:0]   offset_r, offset_s;
  logic [DATA_W-1:0]   data_r, data_s;
  logic                wr_s, busy_s, done_s;

  localparam logic [SLOT_W-1:0] OFFSET_MAX = {SLOT_W{1'b1}};
  localparam logic [SLOT_W-1:0] OFFSET_ONE = {{(SLOT_W-1){1'b0}}, 1'b1};

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      sel_r    <= {SEL_W{1'b0}};
      offset_r <= {SLOT_W{1'b0}};
      data_r   <= {DATA_W{1'b0}};
    end else begin
      state_r  <= state_s;
      sel_r    <= sel_s;
      offset_r <= offset_s;
      data_r   <= data_s;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_s  = state_r;
    sel_s    = sel_r;
    offset_s = offset_r;
    data_s   = data_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          sel_s    = bus.msg_sel;
          offset_s = {SLOT_W{1'b0}};
          state_s  = FETCH;
        end else begin
          state_s  = IDLE;
        end
      end
      FETCH: begin
        state_s = DATA;
      end
      DATA: begin
        if (bus.rd_data == TERM) begin
          state_s = DONE;
        end else begin
          data_s  = bus.rd_data;
          state_s = SEND;
        end
      end
      SEND: begin
        // Last offset of the slot ends the message without needing a terminator.
        if (bus.tx_full) begin
          state_s = SEND;
        end else if (offset_r == OFFSET_MAX) begin
          state_s = DONE;
        end else begin
          offset_s = offset_r + OFFSET_ONE;
          state_s  = FETCH;
        end
      end
      DONE: begin
`ifdef ROM_MSG_SENDER_REPEAT_EN
        if (repeat_mode) begin
          offset_s = {SLOT_W{1'b0}};
          state_s  = FETCH;
        end else begin
          state_s  = IDLE;
        end
`else
        state_s = IDLE;
`endif
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    wr_s   = 1'b0;
    busy_s = 1'b1;
    done_s = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
      end
      SEND: begin
        if (bus.tx_full) begin
          wr_s = 1'b0;
        end else begin
          wr_s = 1'b1;
        end
      end
      DONE: begin
        done_s = 1'b1;
      end
      default: begin
        wr_s = 1'b0;
      end
    endcase
  end

  assign bus.rd_addr   = {sel_r, offset_r};
  assign bus.w_data    = data_r;
  assign bus.wr        = wr_s;
  assign bus.busy      = busy_s;
  assign bus.done_tick = done_s;

endmodule

// File: tb/tb_rom_msg_sender.sv
// Scoreboard bench for rom_msg_sender: a ROM model feeds the DUT, expected
// {addr,byte} items and end-of-message markers are queued at start and matched on wr/done_tick.
module tb_rom_msg_sender;

  logic clk = 1'b0;
  logic reset_n;
`ifdef ROM_MSG_SENDER_REPEAT_EN
  logic repeat_mode;
`endif

  rom_msg_if #(.DATA_W(8), .SEL_W(2), .SLOT_W(6)) bus ();

  rom_msg_sender #(.DATA_W(8), .SEL_W(2), .SLOT_W(6), .TERM(8'h00)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
`ifdef ROM_MSG_SENDER_REPEAT_EN
    .repeat_mode (repeat_mode),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  localparam logic [16:0] MARK = 17'h10000;

  logic [7:0]  rom [256];
  logic [16:0] exp_q [$];
  int checks_n = 0;
  int errors_n = 0;
  int cyc = 0;
  int wr_count = 0;
  int done_count = 0;
  int start_cyc = 0;
  int first_wr_cyc = 0;
  int done_cyc = 0;
  logic first_armed = 1'b0;
  logic prev_wr = 1'b0;
  logic [7:0] last_wr_addr = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_n++;
    if (obs !== exp) begin
      errors_n++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.rd_data <= rom[bus.rd_addr];
  end

  // Scoreboard monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.wr) begin
        check_eq("wr_vs_tx_full", bus.tx_full, 1'b0);
        check_eq("wr_back_to_back", prev_wr, 1'b0);
        if (first_armed) begin
          first_wr_cyc <= cyc;
          first_armed  <= 1'b0;
        end
        wr_count     <= wr_count + 1;
        last_wr_addr <= bus.rd_addr;
        if (exp_q.size() == 0) check_eq("unexpected_wr", 1'b1, 1'b0);
        else check_eq("wr_item", {1'b0, bus.rd_addr, bus.w_data}, exp_q.pop_front());
      end
      if (bus.done_tick) begin
        done_count <= done_count + 1;
        done_cyc   <= cyc;
        if (exp_q.size() == 0) check_eq("unexpected_done", 1'b1, 1'b0);
        else check_eq("done_item", MARK, exp_q.pop_front());
      end
      prev_wr <= bus.wr;
    end else begin
      prev_wr <= 1'b0;
    end
  end

  task automatic push_msg(input logic [1:0] sel);
    logic [7:0] a;
    for (int o = 0; o < 64; o++) begin
      a = {sel, 6'(o)};
      if (rom[a] == 8'h00) break;
      exp_q.push_back({1'b0, a, rom[a]});
    end
    exp_q.push_back(MARK);
  endtask

  // Called at posedge+1; leaves at posedge+1 with busy checked in the FETCH cycle.
  task automatic do_start(input logic [1:0] sel);
    bus.start   = 1'b1;
    bus.msg_sel = sel;
    start_cyc   = cyc;
    first_armed = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.msg_sel = ~sel;
    @(negedge clk);
    check_eq("busy_after_start", bus.busy, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_count < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq("done_timeout", done_count >= target, 1'b1);
  endtask

  task automatic finish_msg(input int target);
    wait_done(target, 600);
    @(negedge clk);
    check_eq("busy_after_done", bus.busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic wait_wr(input int target);
    int n = 0;
    while (wr_count < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    check_eq("wr_timeout", wr_count >= target, 1'b1);
  endtask

  int wr_base;
  int d_base;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h41; rom[8'h01] = 8'h42; rom[8'h02] = 8'h00;
    rom[8'h40] = 8'h48; rom[8'h41] = 8'h69; rom[8'h42] = 8'h0A; rom[8'h43] = 8'h00;
    rom[8'h80] = 8'h00; rom[8'h81] = 8'h55;
    for (int i = 0; i < 64; i++) rom[8'hC0 + i] = 8'h80 + 8'(i);

    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.msg_sel = 2'd0;
    bus.tx_full = 1'b0;
`ifdef ROM_MSG_SENDER_REPEAT_EN
    repeat_mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rd_addr", bus.rd_addr, 8'h00);
    check_eq("rst_wr", bus.wr, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_done", bus.done_tick, 1'b0);
    check_eq("rst_w_data", bus.w_data, 8'h00);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // "Hi\n" from slot 1
    wr_base = wr_count; d_base = done_count;
    push_msg(2'd1);
    do_start(2'd1);
    finish_msg(d_base + 1);
    check_eq("hi_first_wr_lat", first_wr_cyc - start_cyc, 3);
    check_eq("hi_done_lat", done_cyc - start_cyc, 12);
    check_eq("hi_wr_count", wr_count - wr_base, 3);

    // Empty message in slot 2
    wr_base = wr_count; d_base = done_count;
    push_msg(2'd2);
    do_start(2'd2);
    finish_msg(d_base + 1);
    check_eq("empty_done_lat", done_cyc - start_cyc, 3);
    check_eq("empty_wr_count", wr_count - wr_base, 0);

    // Full slot 3 without terminator
    wr_base = wr_count; d_base = done_count;
    push_msg(2'd3);
    do_start(2'd3);
    finish_msg(d_base + 1);
    check_eq("full_wr_count", wr_count - wr_base, 64);
    check_eq("full_last_addr", last_wr_addr, 8'hFF);
    check_eq("full_one_done", done_count - d_base, 1);

    // Backpressure on byte 2 of slot 1
    wr_base = wr_count; d_base = done_count;
    push_msg(2'd1);
    do_start(2'd1);
    wait_wr(wr_base + 1);
    #1 bus.tx_full = 1'b1;
    repeat (10) @(posedge clk);
    check_eq("hold_no_wr", wr_count - wr_base, 1);
    #1 bus.tx_full = 1'b0;
    @(negedge clk);
    check_eq("wr_on_release", bus.wr, 1'b1);
    check_eq("byte_on_release", bus.w_data, 8'h69);
    @(posedge clk); #1;
    finish_msg(d_base + 1);
    check_eq("bp_wr_count", wr_count - wr_base, 3);

    // start while busy is ignored
    wr_base = wr_count; d_base = done_count;
    push_msg(2'd1);
    do_start(2'd1);
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b1; bus.msg_sel = 2'd0;
    @(posedge clk); #1 bus.start = 1'b0;
    finish_msg(d_base + 1);
    repeat (8) @(posedge clk);
    #1;
    check_eq("busy_start_ignored_done", done_count - d_base, 1);
    check_eq("busy_start_ignored_wr", wr_count - wr_base, 3);

    // Reset mid-message, then replay from offset 0
    wr_base = wr_count;
    push_msg(2'd3);
    do_start(2'd3);
    wait_wr(wr_base + 5);
    #1 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_wr", bus.wr, 1'b0);
    check_eq("mid_rst_busy", bus.busy, 1'b0);
    check_eq("mid_rst_rd_addr", bus.rd_addr, 8'h00);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    wr_base = wr_count; d_base = done_count;
    push_msg(2'd3);
    do_start(2'd3);
    finish_msg(d_base + 1);
    check_eq("replay_wr_count", wr_count - wr_base, 64);

`ifdef ROM_MSG_SENDER_REPEAT_EN
    // Repeat "AB" three passes, clearing repeat_mode during the third
    wr_base = wr_count; d_base = done_count;
    push_msg(2'd0); push_msg(2'd0); push_msg(2'd0);
    repeat_mode = 1'b1;
    do_start(2'd0);
    wait_done(d_base + 2, 200);
    #1 repeat_mode = 1'b0;
    finish_msg(d_base + 3);
    repeat (10) @(posedge clk);
    #1;
    check_eq("rep_done_count", done_count - d_base, 3);
    check_eq("rep_wr_count", wr_count - wr_base, 6);
`endif

    check_eq("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule

// File: doc/rom_msg_sender.md
Name: rom_msg_sender

Overview:
- Parametrised message player that streams a terminator-delimited byte string from a synchronous ROM into the UART transmitter.
- ROM holds 2^SEL_W fixed-size slots, one message per slot. A start pulse (typically the debouncer tick) selects the slot via msg_sel.
- Successor to the single-message button sender: adds message selection, honours tx-FIFO backpressure, bounds message length by slot size, reports busy/done.
- Sits between debouncer_fsm/switches, dual_bram_file (read port) and the uart unit.

Parameters:
- DATA_W, 8, byte width of ROM data and w_data
- SEL_W, 2, message-select width; 2^SEL_W slots
- SLOT_W, 6, offset width; slot size 2^SLOT_W bytes
- TERM, 8'h00, end-of-message byte, never transmitted

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; ignored while busy
- msg_sel  in  SEL_W  slot index, sampled on accepted start
- rd_addr  out  SEL_W+SLOT_W  ROM read address = {sel_reg, offset_reg}; ROM has 1-cycle read latency
- rd_data  in  DATA_W  ROM read data
- tx_full  in  1  UART tx FIFO full; wr must not be asserted while high
- wr  out  1  write strobe to UART
- w_data  out  DATA_W  byte to UART, valid when wr=1
- busy  out  1  high from the cycle after an accepted start until the cycle done_tick drops
- done_tick  out  1  one-cycle pulse at end of message

Behaviour:
- Clock and reset: clk; reset_n asynchronous, active-low.
- Reset values: state IDLE, sel_reg=0, offset_reg=0, w_data register=0, wr=0, busy=0, done_tick=0. rd_addr therefore resets to 0.
- States:
  - IDLE: busy=0. On start, latch sel_reg<=msg_sel, offset_reg<=0, go FETCH.
  - FETCH: rd_addr is presented (rd_addr is a registered-value function, stable), go DATA.
  - DATA: rd_data is valid for current offset.
    - If rd_data==TERM, go DONE.
    - Otherwise data_reg<=rd_data, go SEND.
  - SEND: wr = ~tx_full (combinational from state), w_data=data_reg. Stay in SEND while tx_full=1.
    - On wr=1: if offset_reg==2^SLOT_W-1, go DONE (slot exhausted, no terminator needed).
    - Otherwise offset_reg+1, go FETCH.
  - DONE: done_tick=1, busy=1, go IDLE next cycle.
- Cadence: minimum 3 cycles per byte (FETCH, DATA, SEND) with tx_full=0. First wr 3 cycles after the start cycle.
- Empty message (first byte == TERM): done_tick with zero wr pulses.
- Full slot with no TERM: exactly 2^SLOT_W bytes sent, then done_tick.
- start while busy (including in DONE): ignored, not queued. start in the same cycle the FSM is in IDLE is accepted.
- msg_sel changes mid-message: no effect; only sel_reg is used.
- offset_reg never wraps: DONE is taken before increment past max.
- Reset mid-message: immediate return to IDLE, wr drops asynchronously-reset to 0. No partial byte is re-sent after reset.
- wr is never high in consecutive cycles.

Optional Feature:
- Macro: ROM_MSG_SENDER_REPEAT_EN.
- With the macro defined:
  - Extra input repeat_mode (1 bit).
  - In DONE, if repeat_mode=1: offset_reg<=0, go FETCH (same sel_reg). done_tick still pulses once per pass; busy stays 1.
  - Deasserting repeat_mode ends the stream after the current pass completes.
  - An empty message with repeat_mode=1 emits done_tick every 3 cycles, with no wr.
- Without the macro: no repeat_mode port; DONE always goes to IDLE.

Decomposition:
- Package rom_msg_pkg holds:
  - state enum {IDLE, FETCH, DATA, SEND, DONE}
  - localparam ADDR_W = SEL_W+SLOT_W helper function
  - the default TERM constant, shared with the payload-generation script
- Single flat module, no sub-module. The ROM stays external (existing dual_bram_file) so payload images are swappable.

Test Plan:
- ROM slot 1 = "Hi\n",00; start with msg_sel=1, tx_full=0 -> wr pulses with w_data 0x48, 0x69, 0x0A, 3 cycles apart. rd_addr 0x40..0x43. done_tick one cycle after ROM addr 0x43 read; busy low after.
- Slot 2 first byte 00 -> no wr, done_tick 3 cycles after start.
- Slot 3 filled with 64 nonzero bytes, no TERM -> exactly 64 wr, last from rd_addr 0xFF, then done_tick. rd_addr never returns to 0xC0 mid-message.
- Hold tx_full=1 for 10 cycles while in SEND on byte 2 -> wr stays 0; byte 2 is emitted once on the first tx_full=0 cycle, and the byte sequence is unchanged.
- Pulse start with msg_sel=0 while slot 1 is mid-stream -> ignored, slot 1 completes. Assert reset_n=0 mid-message -> wr=0, busy=0, rd_addr=0 immediately; next start replays from offset 0.
- (REPEAT_EN) repeat_mode=1 on "AB",00 -> A,B,done_tick,A,B,done_tick... Clear repeat_mode mid-pass -> the pass finishes, then IDLE.
